// File: rtl/noc_link_arbiter.sv
// -----------------------------------------------------------------------------
// noc_link_arbiter
//   Shares one credit-based valid/yummy NoC link (sender side) between NREQ
//   local requesters. Arbitration is round-robin at packet granularity: once a
//   header flit is accepted, the link stays with that requester until its last
//   body flit. A downstream credit count guarantees that no flit is launched
//   without buffer space at the receiver.
//
// Optional feature macro: NOC_LINK_ARB_STATS_EN
//   When defined, the ports flit_cnt_o and pkt_cnt_o are added.
//
// Ports
//   clk_i         in   1        clock
//   rstn_i        in   1        asynchronous active-low reset
//   req_valid_i   in   NREQ     per-requester flit valid
//   req_data_i    in   NREQ*DW  per-requester flit, requester i at [i*DW +: DW]
//   req_ready_o   out  NREQ     per-requester accept (one-hot or zero)
//   yummy_i       in   1        credit return from downstream, 1 per cycle
//   valid_o       out  1        link flit valid (registered)
//   data_o        out  DW       link flit (registered, holds when idle)
//   credit_err_o  out  1        sticky: yummy_i received with credits full
//   flit_cnt_o    out  32       (stats only) accepted flits, wraps
//   pkt_cnt_o     out  32       (stats only) accepted headers, wraps
// -----------------------------------------------------------------------------
module noc_link_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 64,
    parameter int CREDITS = 8,
    parameter int LEN_LSB = 22,
    parameter int LEN_W   = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    req_ready_o,
    input  logic               yummy_i,
    output logic               valid_o,
    output logic [DW-1:0]      data_o,
    output logic               credit_err_o
`ifdef NOC_LINK_ARB_STATS_EN
    ,
    output logic [31:0]        flit_cnt_o,
    output logic [31:0]        pkt_cnt_o
`endif
);

    localparam int         PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] CRED_FULL = 8'(CREDITS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    logic [0:0]       state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    locked;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       credits;

    logic [PW-1:0]    grant;
    logic             grant_vld;
    logic             accept;
    logic [DW-1:0]    acc_data;
    logic [LEN_W-1:0] acc_len;

    // Successor of a requester index, wrapping at NREQ (not necessarily 2^PW).
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Grant selection. In IDLE the grant is recomputed every cycle from rr_ptr
    // onward, so nothing is locked until a header is actually accepted.
    always_comb begin
        logic found;
        logic [PW-1:0] idx;
        // NOTE: every combinationally written signal gets a default first so
        // no path leaves it unassigned; otherwise a latch is inferred.
        grant     = locked;
        grant_vld = 1'b0;
        found     = 1'b0;
        idx       = '0;
        if (state == ST_BODY) begin
            grant     = locked;
            grant_vld = 1'b1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = PW'((int'(rr_ptr) + k) % NREQ);
                if (!found && req_valid_i[idx]) begin
                    found = 1'b1;
                    grant = idx;
                end
            end
            grant_vld = found;
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_vld && credits != 8'd0)
            req_ready_o[grant] = 1'b1;
    end

    assign accept   = |(req_valid_i & req_ready_o);
    assign acc_data = req_data_i[grant*DW +: DW];
    assign acc_len  = acc_data[LEN_LSB +: LEN_W];

    // Packet FSM and round-robin pointer.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            locked    <= '0;
            remaining <= '0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                if (acc_len == '0) begin
                    rr_ptr <= next_idx(grant);
                end else begin
                    state     <= ST_BODY;
                    locked    <= grant;
                    remaining <= acc_len;
                end
            end else begin
                remaining <= remaining - 1'b1;
                if (remaining == LEN_W'(1)) begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_idx(locked);
                end
            end
        end
    end

    // Credit counter. An accept and a returned credit in the same cycle cancel.
    // A credit returned while already full is dropped and flagged.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            credits      <= CRED_FULL;
            credit_err_o <= 1'b0;
        end else begin
            case ({accept, yummy_i})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits == CRED_FULL) credit_err_o <= 1'b1;
                    else                      credits      <= credits + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Link output register; data_o keeps the last launched flit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= accept;
            if (accept) data_o <= acc_data;
        end
    end

`ifdef NOC_LINK_ARB_STATS_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            flit_cnt_o <= '0;
            pkt_cnt_o  <= '0;
        end else if (accept) begin
            flit_cnt_o <= flit_cnt_o + 32'd1;
            if (state == ST_IDLE) pkt_cnt_o <= pkt_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_link_arbiter
//   Directed, table-driven bench for noc_link_arbiter (NREQ=4, DW=64,
//   CREDITS=8, LEN_LSB=22, LEN_W=8). Each table row gives the inputs for one
//   cycle, the expected combinational ready, and the expected registered link
//   outputs after the following clock edge. Reset-related and stats scenarios
//   are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_noc_link_arbiter;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic [3:0]   req_valid_i = '0;
    logic [255:0] req_data_i = '0;
    logic [3:0]   req_ready_o;
    logic         yummy_i = 1'b0;
    logic         valid_o;
    logic [63:0]  data_o;
    logic         credit_err_o;
`ifdef NOC_LINK_ARB_STATS_EN
    logic [31:0]  flit_cnt_o;
    logic [31:0]  pkt_cnt_o;
`endif

    noc_link_arbiter dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .yummy_i      (yummy_i),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .credit_err_o (credit_err_o)
`ifdef NOC_LINK_ARB_STATS_EN
        ,
        .flit_cnt_o   (flit_cnt_o),
        .pkt_cnt_o    (pkt_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int tag [4]  = '{0, 0, 0, 0};
    logic [63:0] last_data = '0;

    typedef struct {
        bit              rst;   // pulse reset before this row
        logic [3:0]      v;     // req_valid_i
        logic [3:0][7:0] len;   // length field per requester
        logic            y;     // yummy_i
        logic [3:0]      er;    // expected req_ready_o
        logic            ev;    // expected valid_o after the edge
        int              src;   // requester whose flit is launched (-1: none)
        logic            err;   // expected credit_err_o after the edge
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Flit of requester i: id, per-requester tag (advances only on accept,
    // so data stays stable while waiting) and the length field.
    function automatic logic [63:0] flit(input int i, input int t, input logic [7:0] len);
        logic [63:0] f;
        f = '0;
        f[63:56] = 8'(i + 1);
        f[47:32] = 16'(t);
        f[29:22] = len;
        f[15:0]  = ~16'(t);
        return f;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [3:0][7:0] len, input logic y);
        for (int i = 0; i < 4; i++) req_data_i[i*64 +: 64] = flit(i, tag[i], len[i]);
        req_valid_i = v;
        yummy_i     = y;
    endtask

    task automatic do_reset();
        req_valid_i = '0;
        yummy_i     = 1'b0;
        rstn_i      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset valid_o", 64'(valid_o), 64'd0);
        check("reset data_o", data_o, 64'd0);
        check("reset credit_err_o", 64'(credit_err_o), 64'd0);
        rstn_i    = 1'b1;
        last_data = '0;
    endtask

    function automatic void add(input bit rst, input logic [3:0] v, input logic [31:0] len,
                                input logic y, input logic [3:0] er, input logic ev,
                                input int src, input logic err);
        vec_t e;
        e.rst = rst; e.v = v; e.len = len; e.y = y;
        e.er = er; e.ev = ev; e.src = src; e.err = err;
        tbl.push_back(e);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Credit exhaustion: 8 zero-length headers from req0, 9th stalls.
        for (int k = 0; k < 8; k++) add(k == 0, 4'b0001, 32'h0, 1'b0, 4'b0001, 1'b1, 0, 1'b0);
        add(0, 4'b0001, 32'h0, 1'b0, 4'b0000, 1'b0, -1, 1'b0);
        add(0, 4'b0001, 32'h0, 1'b1, 4'b0000, 1'b0, -1, 1'b0);  // credit lands next cycle
        add(0, 4'b0001, 32'h0, 1'b0, 4'b0001, 1'b1, 0, 1'b0);
        // Round robin from a fresh pointer: 0,1,2,3,0.
        add(1, 4'b1111, 32'h0, 1'b0, 4'b0001, 1'b1, 0, 1'b0);
        add(0, 4'b1111, 32'h0, 1'b0, 4'b0010, 1'b1, 1, 1'b0);
        add(0, 4'b1111, 32'h0, 1'b0, 4'b0100, 1'b1, 2, 1'b0);
        add(0, 4'b1111, 32'h0, 1'b0, 4'b1000, 1'b1, 3, 1'b0);
        add(0, 4'b1111, 32'h0, 1'b0, 4'b0001, 1'b1, 0, 1'b0);
        // Refill 3 -> 6 credits.
        for (int k = 0; k < 3; k++) add(0, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, -1, 1'b0);
        // req1 packet of length 3 locks out req2; body length fields ignored.
        add(0, 4'b0110, 32'h0000_0300, 1'b0, 4'b0010, 1'b1, 1, 1'b0);
        for (int k = 0; k < 3; k++) add(0, 4'b0110, 32'h0000_0700, 1'b0, 4'b0010, 1'b1, 1, 1'b0);
        add(0, 4'b0100, 32'h0, 1'b0, 4'b0100, 1'b1, 2, 1'b0);
        // Credits 1: accept -> 0, stall, yummy, accept+yummy keeps 1.
        add(0, 4'b0001, 32'h0, 1'b0, 4'b0001, 1'b1, 0, 1'b0);
        add(0, 4'b0001, 32'h0, 1'b1, 4'b0000, 1'b0, -1, 1'b0);
        add(0, 4'b0001, 32'h0, 1'b1, 4'b0001, 1'b1, 0, 1'b0);
        add(0, 4'b0001, 32'h0, 1'b0, 4'b0001, 1'b1, 0, 1'b0);
        add(0, 4'b0001, 32'h0, 1'b0, 4'b0000, 1'b0, -1, 1'b0);
        // Refill to full, then overflow sets the sticky error.
        for (int k = 0; k < 8; k++) add(0, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, -1, 1'b0);
        add(0, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, -1, 1'b1);
        add(0, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, -1, 1'b1);
        add(0, 4'b0001, 32'h0, 1'b1, 4'b0001, 1'b1, 0, 1'b1);

        for (int n = 0; n < tbl.size(); n++) begin
            if (tbl[n].rst) do_reset();
            drive(tbl[n].v, tbl[n].len, tbl[n].y);
            #1;
            check($sformatf("row%0d ready", n), 64'(req_ready_o), 64'(tbl[n].er));
            if (tbl[n].ev) begin
                last_data = flit(tbl[n].src, tag[tbl[n].src], tbl[n].len[tbl[n].src]);
                tag[tbl[n].src]++;
            end
            @(posedge clk_i);
            #1;
            check($sformatf("row%0d valid_o", n), 64'(valid_o), 64'(tbl[n].ev));
            check($sformatf("row%0d data_o", n), data_o, last_data);
            check($sformatf("row%0d credit_err_o", n), 64'(credit_err_o), 64'(tbl[n].err));
        end

        // Reset in the middle of a req1 packet (remaining=2).
        do_reset();
        drive(4'b0010, 32'h0000_0300, 1'b0);
        #1 check("mid header ready", 64'(req_ready_o), 64'b0010);
        @(posedge clk_i); #1; tag[1]++;
        drive(4'b0010, 32'h0, 1'b0);
        #1 check("mid body ready", 64'(req_ready_o), 64'b0010);
        @(posedge clk_i); #1; tag[1]++;
        check("mid body valid_o", 64'(valid_o), 64'd1);
        rstn_i = 1'b0;
        #1;
        check("async reset valid_o", 64'(valid_o), 64'd0);
        check("async reset data_o", data_o, 64'd0);
        drive(4'b0011, 32'h0, 1'b0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        // Fresh pointer and 8 credits: req0 first, then alternate, 9th stalls.
        for (int k = 0; k < 8; k++) begin
            drive(4'b0011, 32'h0, 1'b0);
            #1 check($sformatf("post-reset ready %0d", k), 64'(req_ready_o),
                     (k % 2 == 0) ? 64'b0001 : 64'b0010);
            @(posedge clk_i); #1;
            tag[k % 2]++;
        end
        drive(4'b0011, 32'h0, 1'b0);
        #1 check("post-reset credits exhausted", 64'(req_ready_o), 64'd0);

`ifdef NOC_LINK_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(4'b0110, (k == 0) ? 32'h0000_0300 : 32'h0, 1'b0);
            #1 check($sformatf("stats pkt ready %0d", k), 64'(req_ready_o), 64'b0010);
            @(posedge clk_i); #1;
            tag[1]++;
        end
        check("stats pkt_cnt_o", 64'(pkt_cnt_o), 64'd1);
        check("stats flit_cnt_o", 64'(flit_cnt_o), 64'd4);
        drive(4'b0100, 32'h0, 1'b0);
        #1 check("stats req2 ready", 64'(req_ready_o), 64'b0100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
